// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default bit timing, receiver states.
// Imported by the receive path and the FIFO it feeds.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int DEF_CLKS_PER_BIT = 10416;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop retires the head.
module byte_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("byte_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  // Masked so the head reads zero whenever nothing is queued.
  assign dout_o  = empty ? '0 : mem_q[rptr_q];
  assign full_o  = full;
  assign empty_o = empty;
  assign count_o = cnt_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with mid-bit sampling feeding a FWFT byte FIFO.
// Framing errors and overruns are reported as one-cycle pulses.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        UART_RXD,
  output logic [UART_DATA_W-1:0]      RX_DAT,
  output logic                        RX_VALID,
  input  logic                        RX_READY,
  output logic [$clog2(FIFO_DEPTH):0] RX_COUNT,
  output logic                        FRAME_ERR,
  output logic                        OVERRUN
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 8) begin : g_bad_cpb
    $error("uart_rx_buffered: CLKS_PER_BIT must be >= 8");
  end

  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  rx_state_e              state_q;
  logic [2:0]             sync_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             bit_q;
  logic [UART_DATA_W-1:0] shf_q;
  logic                   ferr_q;
  logic                   ovr_q;

  logic                   line;
  logic                   fall;
  logic                   half;
  logic                   wrap;
  logic                   push;
  logic                   fifo_full;
  logic                   fifo_empty;

  // sync_q[1] is the synchronised line, sync_q[2] its previous value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], UART_RXD};
    end
  end

  assign line = sync_q[1];
  assign fall = sync_q[2] && !sync_q[1];
  assign half = (cnt_q == HALF);
  assign wrap = (cnt_q == LAST);
  assign push = (state_q == STOP) && wrap && line;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shf_q   <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (half) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= line ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (wrap) begin
            cnt_q <= '0;
            shf_q <= {line, shf_q[UART_DATA_W-1:1]};
            bit_q <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (wrap) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            // A full FIFO still takes the byte if the head leaves now.
            if (line) ovr_q  <= fifo_full && !RX_READY;
            else      ferr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  byte_fifo #(
    .W     (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .push_i  (push),
    .din_i   (shf_q),
    .pop_i   (RX_READY),
    .dout_o  (RX_DAT),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (RX_COUNT)
  );

  assign RX_VALID  = !fifo_empty;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;

endmodule
